stream_pack: RTL and testbench
==============================

// Module: stream_pack
// PURPOSE
//  - Width up-converter on a valid/ready stream: gathers RATIO consecutive WIDTH-bit words into one
//    RATIO*WIDTH-bit word. Sits directly downstream of the skid buffer and consumes its output stream.
//  - Full throughput: accepts one input word per cycle while the output side keeps up.
// PARAMETERS
//  WIDTH  16  input word width, bits (>=1)
//  RATIO  4   input words per output word (>=2)
// PORTS
//  i_clock      in   1              rising-edge clock
//  i_reset      in   1              asynchronous, active-high reset
//  i_in_data    in   WIDTH          upstream data
//  i_in_valid   in   1              upstream valid
//  o_in_ready   out  1              upstream ready
//  o_out_data   out  WIDTH*RATIO    packed data; lane k = bits [k*WIDTH +: WIDTH]
//  o_out_valid  out  1              downstream valid
//  i_out_ready  in   1              downstream ready
//  i_flush      in   1              [STREAM_PACK_FLUSH_EN only] emit partial word
//  o_out_lanes  out  $clog2(RATIO+1)  [STREAM_PACK_FLUSH_EN only] valid lanes in o_out_data
// BEHAVIOUR
//  - Reset (async assert, sync release): lane count=0, accumulator=0, o_out_valid=0, o_out_data=0,
//    o_out_lanes=0, flush-pending=0. o_in_ready = 1 during and after reset.
//  - Transfer on either side only when valid & ready are both high at a rising edge.
//  - Storage: accumulator of RATIO-1 lanes + output register. The lane count (0..RATIO-1) is the FSM state.
//  - Lane order: the first accepted word goes to lane 0 (LSBs); the RATIO-th goes to lane RATIO-1 (MSBs).
//  - The input word at count=c (c<RATIO-1) is stored in lane c; count becomes c+1.
//  - Input at count=RATIO-1: output register <= {in, accumulator lanes}; o_out_valid=1; count=0.
//  - Latency: packed word is valid the cycle after the RATIO-th word is accepted.
//  - o_in_ready = (count != RATIO-1) | ~o_out_valid | i_out_ready (combinational).
//    - Never stall while free lanes remain.
//    - Stall only on the final lane while the output register is full and not draining.
//  - Output drain and new-word load in the same cycle: the new word replaces the old one; o_out_valid stays 1.
//  - Drain with no load: o_out_valid -> 0. o_out_data holds its last value; contents are don't-care while invalid.
//  - o_out_data / o_out_valid are stable while o_out_valid=1 & i_out_ready=0 (AXI-style hold).
//  - Count wraps RATIO-1 -> 0 only on a completed word. No other wrap exists.
//  - Unused accumulator lanes are zeroed when a word is launched.
//  - Reset mid-word: partial lanes are discarded, and no output is produced for them.
// CONFIGURATION
//  - STREAM_PACK_FLUSH_EN defined:
//    - Adds i_flush and o_out_lanes.
//    - i_flush=1 at an edge sets flush-pending. Flush-pending clears when its word launches or when count=0 with no input.
//    - Input accepted in the same cycle as flush is included in the flushed word.
//    - While flush-pending with count>0, the partial word loads into the output register at the first edge
//      the register is free or draining. Upper lanes are zero; o_out_lanes = lanes filled; count -> 0.
//    - o_in_ready = 0 while a pending flush waits for the output register.
//    - Full words: o_out_lanes = RATIO.
//    - Flush at count=0 with no input: no output.
//  - Undefined: no i_flush, no o_out_lanes. Partial words wait indefinitely for more input.
// TESTING (WIDTH=16, RATIO=4)
//  1. i_out_ready=1; inputs 1,2,3,4 back-to-back -> one output 64'h0004_0003_0002_0001, valid 1 cycle after 4th accept.
//  2. i_out_ready=0; i_in_valid=1 continuously, incrementing data -> exactly 7 words accepted, then o_in_ready=0.
//     Raise ready -> outputs 0x0004..0001 then 0x0008..0005, in order.
//  3. i_in_valid and i_out_ready both continuously 1, 40 words -> 10 outputs, o_in_ready never low, no gaps after first.
//  4. Bursty valid and ready, pseudo-random, 400 words -> 100 outputs matching the reference packing; no loss or duplication.
//  5. Reset asserted after 2 words; then 4 words 9,10,11,12 -> single output 0x000C_000B_000A_0009.
//  6. [FLUSH_EN] words 5,6 then i_flush -> output 0x0000_0000_0006_0005, o_out_lanes=2.
//     Next full word has o_out_lanes=4.

Source files
------------

// File: rtl/stream_pack.sv
// Valid/ready width up-converter: packs RATIO WIDTH-bit words into one output word.
// Optional partial-word flush with lane count when STREAM_PACK_FLUSH_EN is defined.
module stream_pack #(
    parameter int WIDTH = 16,
    parameter int RATIO = 4
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [WIDTH-1:0]         i_in_data,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    output logic [WIDTH*RATIO-1:0]   o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready
`ifdef STREAM_PACK_FLUSH_EN
    ,
    input  logic                     i_flush,
    output logic [$clog2(RATIO+1)-1:0] o_out_lanes
`endif
);

    localparam int CW = $clog2(RATIO);
    localparam int LW = $clog2(RATIO + 1);
    localparam int AW = (RATIO - 1) * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    logic [CW-1:0]          count_q, count_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic [WIDTH*RATIO-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   out_free;
    logic                   in_ready;
    logic                   in_fire;

`ifdef STREAM_PACK_FLUSH_EN
    logic [LW-1:0]          lanes_q, lanes_d;
    logic                   pend_q, pend_d;
    logic                   flush_go;
`endif

    always_comb begin
        count_d  = count_q;
        acc_d    = acc_q;
        data_d   = data_q;
        valid_d  = valid_q;
        out_free = ~valid_q | i_out_ready;
`ifdef STREAM_PACK_FLUSH_EN
        lanes_d  = lanes_q;
        // Input is held off until a pending partial word has launched.
        flush_go = pend_q & (count_q != '0);
        in_ready = ((count_q != LAST) | out_free) & ~flush_go;
`else
        in_ready = (count_q != LAST) | out_free;
`endif
        in_fire  = i_in_valid & in_ready;

        if (valid_q & i_out_ready) begin
            valid_d = 1'b0;
        end

        if (in_fire) begin
            if (count_q == LAST) begin
                data_d  = {i_in_data, acc_q};
                valid_d = 1'b1;
                count_d = '0;
                acc_d   = '0;
`ifdef STREAM_PACK_FLUSH_EN
                lanes_d = LW'(RATIO);
`endif
            end else begin
                acc_d[int'(count_q)*WIDTH +: WIDTH] = i_in_data;
                count_d = count_q + CW'(1);
            end
        end

`ifdef STREAM_PACK_FLUSH_EN
        // Lanes at and above count are already zero in the accumulator.
        if (flush_go & out_free) begin
            data_d  = {{WIDTH{1'b0}}, acc_q};
            valid_d = 1'b1;
            lanes_d = LW'(count_q);
            count_d = '0;
            acc_d   = '0;
        end
        pend_d = (pend_q | i_flush) & (count_d != '0);
`endif
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

`ifdef STREAM_PACK_FLUSH_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            lanes_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            lanes_q <= lanes_d;
            pend_q  <= pend_d;
        end
    end

    assign o_out_lanes = lanes_q;
`endif

    assign o_in_ready  = in_ready;
    assign o_out_data  = data_q;
    assign o_out_valid = valid_q;

endmodule

// File: tb/tb_stream_pack.sv
// Directed bench for stream_pack (WIDTH=16, RATIO=4): vector table plus
// hand-written sequences for back-pressure, streaming, reset and flush.
module tb_stream_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        o_in_ready;
    logic [63:0] o_out_data;
    logic        o_out_valid;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  o_out_lanes;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_pack #(.WIDTH(16), .RATIO(4)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_in_data  (in_data),
        .i_in_valid (in_valid),
        .o_in_ready (o_in_ready),
        .o_out_data (o_out_data),
        .o_out_valid(o_out_valid),
        .i_out_ready(out_ready)
`ifdef STREAM_PACK_FLUSH_EN
        ,
        .i_flush    (flush),
        .o_out_lanes(o_out_lanes)
`endif
    );

`ifndef STREAM_PACK_FLUSH_EN
    assign o_out_lanes = 3'd0;
`endif

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        r;
        logic        eir;
        logic        eov;
        logic [63:0] eod;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask

    // Drive at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic v, input logic [15:0] d,
                         input logic r, input logic f);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    initial begin
        logic [63:0] exp;
        logic [63:0] held;
        logic        hold;
        logic [15:0] w[400];
        logic        v;
        logic        r;
        int outs;
        int last;
        int na;
        int no;
        int cyc;

        // Test 1: four words with ready high
        tbl[0]  = '{1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 64'd0};
        tbl[1]  = '{1'b1, 16'd2, 1'b1, 1'b1, 1'b0, 64'd0};
        tbl[2]  = '{1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 64'd0};
        tbl[3]  = '{1'b1, 16'd4, 1'b1, 1'b1, 1'b0, 64'd0};
        tbl[4]  = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 64'h0004_0003_0002_0001};
        tbl[5]  = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 64'd0};
        // Test 2: output blocked, seven words accepted then stall
        tbl[6]  = '{1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 64'd0};
        tbl[7]  = '{1'b1, 16'd2, 1'b0, 1'b1, 1'b0, 64'd0};
        tbl[8]  = '{1'b1, 16'd3, 1'b0, 1'b1, 1'b0, 64'd0};
        tbl[9]  = '{1'b1, 16'd4, 1'b0, 1'b1, 1'b0, 64'd0};
        tbl[10] = '{1'b1, 16'd5, 1'b0, 1'b1, 1'b1, 64'h0004_0003_0002_0001};
        tbl[11] = '{1'b1, 16'd6, 1'b0, 1'b1, 1'b1, 64'h0004_0003_0002_0001};
        tbl[12] = '{1'b1, 16'd7, 1'b0, 1'b1, 1'b1, 64'h0004_0003_0002_0001};
        tbl[13] = '{1'b1, 16'd8, 1'b0, 1'b0, 1'b1, 64'h0004_0003_0002_0001};
        tbl[14] = '{1'b1, 16'd8, 1'b1, 1'b1, 1'b1, 64'h0004_0003_0002_0001};
        tbl[15] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b1, 64'h0008_0007_0006_0005};
        tbl[16] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 64'd0};

        // Reset state
        #1;
        chk("rst_valid", o_out_valid, 0);
        chk("rst_data", o_out_data, 0);
        chk("rst_ready", o_in_ready, 1);
        chk("rst_lanes", o_out_lanes, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", o_in_ready, 1);
        chk("post_rst_valid", o_out_valid, 0);

        // Tests 1 and 2 from the table
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0);
            chk($sformatf("vec%0d_ready", i), o_in_ready, tbl[i].eir);
            chk($sformatf("vec%0d_valid", i), o_out_valid, tbl[i].eov);
            if (tbl[i].eov)
                chk($sformatf("vec%0d_data", i), o_out_data, tbl[i].eod);
        end

        // Test 3: continuous streaming, 40 words
        outs = 0;
        last = 0;
        for (int i = 0; i < 44; i++) begin
            drive(i < 40, 16'(i + 1), 1'b1, 1'b0);
            if (i < 40)
                chk("t3_ready", o_in_ready, 1);
            if (o_out_valid) begin
                exp = {16'(4 * outs + 4), 16'(4 * outs + 3),
                       16'(4 * outs + 2), 16'(4 * outs + 1)};
                chk("t3_data", o_out_data, exp);
                if (outs > 0)
                    chk("t3_spacing", 64'(i - last), 64'd4);
                last = i;
                outs++;
            end
        end
        chk("t3_outputs", 64'(outs), 64'd10);

        // Test 4: bursty valid/ready with hold checks
        for (int i = 0; i < 400; i++)
            w[i] = 16'($urandom);
        na = 0;
        no = 0;
        cyc = 0;
        hold = 1'b0;
        held = '0;
        while (no < 100 && cyc < 6000) begin
            v = (na < 400) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            drive(v, w[na % 400], r, 1'b0);
            if (hold) begin
                chk("t4_hold_valid", o_out_valid, 1);
                chk("t4_hold_data", o_out_data, held);
            end
            hold = o_out_valid && !r;
            held = o_out_data;
            if (o_out_valid && r) begin
                exp = {w[4*no+3], w[4*no+2], w[4*no+1], w[4*no]};
                chk("t4_data", o_out_data, exp);
                no++;
            end
            if (v && o_in_ready)
                na++;
            cyc++;
        end
        chk("t4_outputs", 64'(no), 64'd100);
        chk("t4_accepted", 64'(na), 64'd400);

        // Test 5: reset in the middle of a word
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        drive(1'b1, 16'd7, 1'b1, 1'b0);
        drive(1'b1, 16'd8, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", o_out_valid, 0);
        chk("t5_rst_data", o_out_data, 0);
        chk("t5_rst_ready", o_in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 16'(9 + k), 1'b1, 1'b0);
            chk("t5_no_output", o_out_valid, 0);
        end
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        chk("t5_valid", o_out_valid, 1);
        chk("t5_data", o_out_data, 64'h000C_000B_000A_0009);

`ifdef STREAM_PACK_FLUSH_EN
        // Test 6: partial word flush, then a full word
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        drive(1'b1, 16'd5, 1'b1, 1'b0);
        drive(1'b1, 16'd6, 1'b1, 1'b0);
        drive(1'b0, 16'd0, 1'b1, 1'b1);
        chk("t6_ready_at_flush", o_in_ready, 1);
        drive(1'b1, 16'd99, 1'b1, 1'b0);
        chk("t6_flush_stall", o_in_ready, 0);
        chk("t6_not_yet", o_out_valid, 0);
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        chk("t6_flush_valid", o_out_valid, 1);
        chk("t6_flush_data", o_out_data, 64'h0000_0000_0006_0005);
        chk("t6_flush_lanes", o_out_lanes, 2);
        chk("t6_ready_after", o_in_ready, 1);
        for (int k = 0; k < 4; k++)
            drive(1'b1, 16'(k + 1), 1'b1, 1'b0);
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        chk("t6_full_valid", o_out_valid, 1);
        chk("t6_full_data", o_out_data, 64'h0004_0003_0002_0001);
        chk("t6_full_lanes", o_out_lanes, 4);
        drive(1'b0, 16'd0, 1'b1, 1'b1);
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        drive(1'b0, 16'd0, 1'b1, 1'b0);
        chk("t6_empty_flush", o_out_valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
